// File: rtl/p2s_lanes.sv
// p2s_lanes: splits each DATA_W-bit word into LANES slices and shifts them out
// in parallel, one bit per lane per beat, with a one-word holding buffer.
module p2s_lanes #(
   parameter int DATA_W    = 32,
   parameter int LANES     = 4,
   parameter int MSB_FIRST = 1,
   localparam int BEATS    = DATA_W / LANES,
   localparam int SEL_W    = BEATS > 1 ? $clog2(BEATS) : 1
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic              ENB,
   input  logic [DATA_W-1:0] data_in,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [LANES-1:0]  data_out,
   output logic              out_valid,
   output logic              frame_start,
   output logic [SEL_W-1:0]  sel
);
   typedef enum logic {IDLE, SHIFT} state_t;
   state_t             state_q, state_d;
   logic [DATA_W-1:0]  word_q, word_d, hold_q, hold_d;
   logic               hold_vld_q, hold_vld_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic [LANES-1:0]   dout_q, dout_d;
   logic               ov_q, ov_d, fs_q, fs_d;
   logic               accept, last;

   function automatic logic [LANES-1:0] beat_bits(input logic [DATA_W-1:0] w, input logic [SEL_W-1:0] b);
      for (int k = 0; k < LANES; k++)
         beat_bits[k] = w[k*BEATS + (MSB_FIRST != 0 ? BEATS-1-int'(b) : int'(b))];
   endfunction

   assign in_ready = ENB && !hold_vld_q && !reset;
   assign accept   = in_valid && in_ready;
   assign last     = sel_q == SEL_W'(BEATS-1);

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         word_q     <= '0;
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
         sel_q      <= '0;
         dout_q     <= '0;
         ov_q       <= 1'b0;
         fs_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         word_q     <= word_d;
         hold_q     <= hold_d;
         hold_vld_q <= hold_vld_d;
         sel_q      <= sel_d;
         dout_q     <= dout_d;
         ov_q       <= ov_d;
         fs_q       <= fs_d;
      end
   end

   always_comb begin
      state_d = !ENB ? state_q :
                state_q == IDLE ? (accept ? SHIFT : IDLE) :
                (last && !hold_vld_q && !accept) ? IDLE : SHIFT;
   end

   // The hold word wins over a fresh accept at the last beat; in_ready is low then anyway.
   always_comb begin
      word_d     = word_q;
      hold_d     = hold_q;
      hold_vld_d = hold_vld_q;
      sel_d      = sel_q;
      fs_d       = fs_q;
      ov_d       = ov_q;
      dout_d     = dout_q;
      if (ENB) begin
         if (state_q == SHIFT && !last) begin
            sel_d = sel_q + SEL_W'(1);
            fs_d  = 1'b0;
            if (accept) begin
               hold_d     = data_in;
               hold_vld_d = 1'b1;
            end
         end else if (state_q == SHIFT && hold_vld_q) begin
            word_d     = hold_q;
            hold_vld_d = 1'b0;
            sel_d      = '0;
            fs_d       = 1'b1;
         end else if (accept) begin
            word_d = data_in;
            sel_d  = '0;
            fs_d   = 1'b1;
         end else begin
            sel_d = '0;
            fs_d  = 1'b0;
         end
         ov_d   = state_d == SHIFT;
         dout_d = ov_d ? beat_bits(word_d, sel_d) : '0;
      end
   end

   always_comb begin
      data_out    = dout_q;
      out_valid   = ov_q;
      frame_start = fs_q;
      sel         = sel_q;
   end
endmodule
